i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter QTR, default 5: SCL quarter-period in clk cycles (>=2); one bit time = 4*QTR cycles.
REQ-002 Port clk  in  1  system clock; all state on rising edge.
REQ-003 Port RESET  in  1  asynchronous, active-low reset.
REQ-004 Port start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 Port rw  in  1  0 = write, 1 = read; captured with start.
REQ-006 Port addr  in  7  target address (bench default 7'h67); captured with start.
REQ-007 Port wdata  in  8  write byte; captured with start.
REQ-008 Port busy  out  1  high from accepted start until done.
REQ-009 Port done  out  1  one-cycle pulse at transaction end.
REQ-010 Port ack_err  out  1  valid with done; 1 = slave NACKed address or write data.
REQ-011 Port rdata  out  8  read byte; valid with done when rw=1, held until next done.
REQ-012 Port SCL  out  1  bus clock, push-pull; idle high.
REQ-013 Port SDA  inout  1  open-drain: driven 0 or released to Z, never driven 1.

Function
REQ-014 Each bit shall have four QTR-cycle phases: P0 SCL low, SDA updated at start; P1 SCL low; P2 SCL high; P3 SCL high, SDA sampled at start of P3.
REQ-015 States: IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP.
REQ-016 IDLE: SCL=1, SDA released; start=1 -> capture inputs, busy=1, next cycle enter START.
REQ-017 START (one bit time): SDA released while SCL high for first half, pulled 0 while SCL high for second half, SCL then falls.
REQ-018 ADDR: send byte {addr,rw} LSB first, i.e. bit0 = rw first, then addr[0]..addr[6]; 8 bit times.
REQ-019 ADDR_ACK: SDA released; sampled 0 -> WDATA (rw=0) or RDATA (rw=1); sampled 1 -> ack_err=1, STOP.
REQ-020 WDATA: send wdata LSB first; WDATA_ACK: release SDA, sample; 1 sets ack_err; always -> STOP.
REQ-021 RDATA: SDA released; shift sampled bits LSB first into rdata shadow register; RDATA_ACK: master releases SDA (NACK, single-byte read) -> STOP.
REQ-022 STOP (one bit time): SDA 0 while SCL low, SCL rises, SDA released while SCL high.
REQ-023 done pulses and rdata/ack_err update in the cycle after STOP completes; busy falls in the same cycle; return to IDLE.
REQ-024 Full transaction latency: start accept to done = 20 bit times = 80*QTR cycles (+1 capture cycle), identical for read and write; NACKed address = 11 bit times.
REQ-025 start while busy shall be ignored, with no queueing.
REQ-026 ack_err cleared on each accepted start.

Reset
REQ-027 RESET low shall immediately (asynchronously) force IDLE, SCL=1, SDA released, busy=0, done=0, ack_err=0, rdata=8'h00, phase counters 0.
REQ-028 Reset mid-transfer shall not generate a STOP; the bus is simply released.

Structure
REQ-029 Package i2c_pkg shall hold the state enum, RW_WRITE=0/RW_READ=1 constants, and DEFAULT_SLAVE_ADDR=7'h67.
REQ-030 One sub-module i2c_bit_timer shall provide the QTR counter and 2-bit phase index with a bit_end strobe.

Verification
REQ-031 Write addr=7'h67, wdata=8'hDD, ACKing slave model: SDA bits after START = 0,1,1,1,0,0,1,1 (8'hCE LSB first), ACK, 1,0,1,1,1,0,1,1, ACK, STOP; done at 401 cycles (QTR=5), ack_err=0.
REQ-032 Read addr=7'h67, slave returns 8'hA5: address bits follow 8'hCF LSB first; rdata=8'hA5 at done; master leaves SDA released at 9th data clock.
REQ-033 Address 7'h6E with no slave responding (SDA pulled up) -> STOP after ADDR_ACK, done with ack_err=1, total 11 bit times.
REQ-034 Slave NACKs write data -> ack_err=1 at done, STOP still issued.
REQ-035 start pulsed again mid-transfer -> ignored; RESET asserted during WDATA -> SCL=1, SDA=Z same cycle, busy=0, no done pulse.
REQ-036 Bus checker: SDA never driven 1; SDA changes only while SCL low except START/STOP edges.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StStop
  } i2c_state_e;

  localparam logic       RW_WRITE           = 1'b0;
  localparam logic       RW_READ            = 1'b1;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h67;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period counter and 2-bit phase index; strobes mark the SDA sample point and bit end.
module i2c_bit_timer #(
  parameter int unsigned QTR = 5
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       run_i,
  output logic [1:0] phase_o,
  output logic       sample_o,
  output logic       bit_end_o
);

  localparam int unsigned CntW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(QTR - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      phase_q, phase_d;
  logic            qtr_end;

  assign qtr_end = run_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = 2'd0;
    end else if (qtr_end) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Sampling happens on the edge that enters P3.
  assign phase_o   = phase_q;
  assign sample_o  = qtr_end && (phase_q == 2'd2);
  assign bit_end_o = qtr_end && (phase_q == 2'd3);

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+rw, one data byte (write or read), STOP.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned QTR = 5
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       SCL,
  inout  wire        SDA
);

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       ack_err_q, ack_err_d;
  logic       done_q, done_d;
  logic [1:0] phase;
  logic       sample, bit_end, sda_low;
  logic [7:0] addr_byte;

  assign addr_byte = {addr_q, rw_q};
  assign busy      = (state_q != StIdle);

  i2c_bit_timer #(
    .QTR(QTR)
  ) u_timer (
    .clk      (clk),
    .RESET    (RESET),
    .run_i    (busy),
    .phase_o  (phase),
    .sample_o (sample),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rw_d      = rw;
          addr_d    = addr;
          wdata_d   = wdata;
          rx_d      = 8'h00;
          err_d     = 1'b0;
          ack_err_d = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = StStart;
        end
      end
      StStart: if (bit_end) state_d = StAddr;
      StAddr: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StAddrAck;
        end
      end
      StAddrAck: begin
        if (sample && SDA) err_d = 1'b1;
        if (bit_end) state_d = err_q ? StStop : ((rw_q == RW_READ) ? StRdata : StWdata);
      end
      StWdata: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StWdataAck;
        end
      end
      StWdataAck: begin
        if (sample && SDA) err_d = 1'b1;
        if (bit_end) state_d = StStop;
      end
      StRdata: begin
        if (sample) rx_d[bit_cnt_q] = SDA;
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StRdataAck;
        end
      end
      StRdataAck: if (bit_end) state_d = StStop;
      StStop: begin
        if (bit_end) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          ack_err_d = err_q;
          if (rw_q == RW_READ) rdata_d = rx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus pins decode straight from state so reset releases them without waiting for a clock.
  always_comb begin
    SCL     = 1'b1;
    sda_low = 1'b0;
    unique case (state_q)
      StIdle:  SCL = 1'b1;
      StStart: sda_low = phase[1];
      StAddr: begin
        SCL     = phase[1];
        sda_low = ~addr_byte[bit_cnt_q];
      end
      StWdata: begin
        SCL     = phase[1];
        sda_low = ~wdata_q[bit_cnt_q];
      end
      StStop: begin
        SCL     = phase[1];
        sda_low = (phase != 2'd3);
      end
      default: SCL = phase[1];
    endcase
  end

  assign SDA = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      rw_q      <= RW_WRITE;
      addr_q    <= 7'h00;
      wdata_q   <= 8'h00;
      rx_q      <= 8'h00;
      rdata_q   <= 8'h00;
      err_q     <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: slave model on SDA, bus monitor, bit-list reference model per transaction.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int unsigned QTR  = 5;
  localparam int          BitT = 4 * QTR;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, ack_err, scl;
  logic [7:0] rdata;
  wire        sda;

  int vec  = 0;
  int errs = 0;

  pullup (sda);

  i2c_master #(
    .QTR(QTR)
  ) dut (
    .clk    (clk),
    .RESET  (RESET),
    .start  (start),
    .rw     (rw),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err),
    .rdata  (rdata),
    .SCL    (scl),
    .SDA    (sda)
  );

  always #5 clk = ~clk;

  // Slave: slot k is the bus bit that began at the k-th SCL fall of the transaction.
  int         slv_base = 0;
  logic       slv_rw = 1'b0, slv_ack_a = 1'b0, slv_ack_d = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  logic       slv_pull;
  int         slot;
  int         neg_cnt = 0;

  always_comb begin
    slot     = neg_cnt - slv_base;
    slv_pull = 1'b0;
    if (slv_ack_a) begin
      if (slot == 9) slv_pull = 1'b1;
      else if (slv_rw && slot >= 10 && slot <= 17) slv_pull = !slv_byte[slot-10];
      else if (!slv_rw && slot == 18 && slv_ack_d) slv_pull = 1'b1;
    end
  end

  assign sda = slv_pull ? 1'b0 : 1'bz;

  // Bus monitor on the falling clock edge.
  int   rise_cnt = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0, xz_cnt = 0;
  logic rises [0:4095];
  logic scl_prev = 1'b1, sda_prev = 1'b1;

  always @(negedge clk) begin
    if (!scl && scl_prev) neg_cnt <= neg_cnt + 1;
    if (scl && !scl_prev && rise_cnt < 4096) begin
      rises[rise_cnt] <= sda;
      rise_cnt        <= rise_cnt + 1;
    end
    if (scl && scl_prev && sda_prev && !sda) start_cnt <= start_cnt + 1;
    if (scl && scl_prev && !sda_prev && sda) stop_cnt <= stop_cnt + 1;
    if (sda !== 1'b0 && sda !== 1'b1) xz_cnt <= xz_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    scl_prev <= scl;
    sda_prev <= sda;
  end

  task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wd,
                         input logic t_acka, input logic t_ackd, input logic [7:0] t_sb,
                         input int inject, input string name);
    logic [7:0] ab;
    logic       exp_bits [0:18];
    int         n, exp_cyc, rb, sb0, sp0, d0, edges, bad_at;
    logic       exp_err, got;
    ab = {t_addr, t_rw};
    n  = 0;
    for (int i = 0; i < 8; i++) begin exp_bits[n] = ab[i]; n++; end
    exp_bits[n] = !t_acka; n++;
    if (t_acka) begin
      for (int i = 0; i < 8; i++) begin exp_bits[n] = t_rw ? t_sb[i] : t_wd[i]; n++; end
      exp_bits[n] = t_rw ? 1'b1 : !t_ackd; n++;
    end
    exp_bits[n] = 1'b0; n++;
    exp_cyc = (t_acka ? 20 : 11) * BitT + 1;
    exp_err = !t_acka || (!t_rw && !t_ackd);

    @(negedge clk);
    slv_base  = neg_cnt;
    slv_rw    = t_rw;
    slv_ack_a = t_acka;
    slv_ack_d = t_ackd;
    slv_byte  = t_sb;
    rb = rise_cnt; sb0 = start_cnt; sp0 = stop_cnt; d0 = done_cnt;
    rw = t_rw; addr = t_addr; wdata = t_wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    vec++;
    if (busy !== 1'b1 || ack_err !== 1'b0) begin
      errs++;
      $display("FAIL %s accept: busy=%b ack_err=%b, want busy=1 ack_err=0", name, busy, ack_err);
    end
    got = 1'b0;
    while (!got && edges < 600) begin
      if (inject > 0 && edges == inject) begin
        start = 1'b1; rw = ~t_rw; addr = ~t_addr; wdata = ~t_wd;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    vec++;
    if (!got || edges != exp_cyc) begin
      errs++;
      $display("FAIL %s latency: got %0d cycles (done seen=%b), want %0d", name, edges, got,
               exp_cyc);
    end
    vec++;
    if (busy !== 1'b0 || ack_err !== exp_err) begin
      errs++;
      $display("FAIL %s status: busy=%b ack_err=%b, want busy=0 ack_err=%b", name, busy, ack_err,
               exp_err);
    end
    if (t_rw && t_acka) begin
      vec++;
      if (rdata !== t_sb) begin
        errs++;
        $display("FAIL %s rdata: got %h, want %h", name, rdata, t_sb);
      end
    end
    bad_at = -1;
    if (rise_cnt - rb == n) begin
      for (int i = n - 1; i >= 0; i--) if (rises[rb+i] !== exp_bits[i]) bad_at = i;
    end
    vec++;
    if (rise_cnt - rb != n || bad_at >= 0) begin
      errs++;
      $display("FAIL %s sda bits: %0d SCL rises (first bad bit %0d), want %0d rises", name,
               rise_cnt - rb, bad_at, n);
    end
    vec++;
    if (start_cnt - sb0 != 1 || stop_cnt - sp0 != 1) begin
      errs++;
      $display("FAIL %s bus conditions: %0d START %0d STOP, want 1 and 1", name,
               start_cnt - sb0, stop_cnt - sp0);
    end
    @(posedge clk); #1;
    vec++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1 || scl !== 1'b1) begin
      errs++;
      $display("FAIL %s after done: done=%b busy=%b scl=%b pulses=%0d, want 0 0 1 and 1 pulse",
               name, done, busy, scl, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    #2 RESET = 1'b0;
    #1;
    vec++;
    if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ack_err !== 1'b0 ||
        rdata !== 8'h00) begin
      errs++;
      $display("FAIL reset state: scl=%b sda=%b busy=%b done=%b ack_err=%b rdata=%h, want 1 1 0 0 0 00",
               scl, sda, busy, done, ack_err, rdata);
    end
    repeat (3) @(posedge clk);
    #2 RESET = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    run_txn(RW_WRITE, DEFAULT_SLAVE_ADDR, 8'hDD, 1'b1, 1'b1, 8'h00, 0, "write_67_dd");
  endtask

  task automatic test_read();
    run_txn(RW_READ, DEFAULT_SLAVE_ADDR, 8'h00, 1'b1, 1'b0, 8'hA5, 0, "read_67_a5");
  endtask

  task automatic test_nack_addr();
    run_txn(RW_WRITE, 7'h6E, 8'h3C, 1'b0, 1'b0, 8'h00, 0, "nack_addr_6e");
  endtask

  task automatic test_nack_data();
    run_txn(RW_WRITE, DEFAULT_SLAVE_ADDR, 8'h81, 1'b1, 1'b0, 8'h00, 0, "nack_wdata");
  endtask

  task automatic test_busy_ignore();
    run_txn(RW_WRITE, 7'h12, 8'h5A, 1'b1, 1'b1, 8'h00, 100, "start_while_busy");
    repeat (30) @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b0 || scl !== 1'b1) begin
      errs++;
      $display("FAIL start_while_busy queued: busy=%b scl=%b, want 0 1", busy, scl);
    end
  endtask

  task automatic test_reset_mid();
    int guard, d0;
    @(negedge clk);
    slv_base = neg_cnt; slv_rw = 1'b0; slv_ack_a = 1'b1; slv_ack_d = 1'b1;
    rw = RW_WRITE; addr = DEFAULT_SLAVE_ADDR; wdata = 8'h00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    while (neg_cnt - slv_base < 12 && guard < 600) begin @(posedge clk); guard++; end
    vec++;
    if (guard >= 600) begin
      errs++;
      $display("FAIL reset_mid reach wdata: waited %0d cycles, want under 600", guard);
    end
    @(posedge clk);
    #3;
    d0 = done_cnt;
    RESET = 1'b0;
    slv_ack_a = 1'b0;
    #1;
    vec++;
    if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid immediate: scl=%b sda=%b busy=%b done=%b, want 1 1 0 0", scl, sda,
               busy, done);
    end
    repeat (2) @(posedge clk);
    #2 RESET = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    vec++;
    if (done_cnt != d0 || busy !== 1'b0 || scl !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid aftermath: %0d done pulses busy=%b scl=%b, want 0 pulses 0 1",
               done_cnt - d0, busy, scl);
    end
  endtask

  task automatic test_random();
    logic       r_rw, r_acka, r_ackd;
    logic [6:0] r_addr;
    logic [7:0] r_wd, r_sb;
    for (int i = 0; i < 8; i++) begin
      r_rw   = 1'($urandom % 2);
      r_addr = 7'($urandom);
      r_wd   = 8'($urandom);
      r_sb   = 8'($urandom);
      r_acka = ($urandom % 4) != 0;
      r_ackd = ($urandom % 3) != 0;
      run_txn(r_rw, r_addr, r_wd, r_acka, r_ackd, r_sb, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_txn(RW_READ, 7'h2B, 8'h00, 1'b1, 1'b0, 8'h3C, 0, "b2b_read0");
    run_txn(RW_READ, 7'h2B, 8'h00, 1'b1, 1'b0, 8'hC3, 0, "b2b_read1");
  endtask

  task automatic test_bus_levels();
    vec++;
    if (xz_cnt != 0) begin
      errs++;
      $display("FAIL sda level: %0d samples neither 0 nor 1, want 0", xz_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack_addr();
    test_nack_data();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_bus_levels();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
